// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - sm83 front end: PC/IR ownership, fetch address mux, opcode decode
module fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_sel,
  input  logic        inc_pc,
  input  logic        mem_to_ir,
  input  logic        halt,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [1:0]  ctl_op,
  output logic [2:0]  r8_dst,
  output logic [2:0]  r8_src,
  output logic [2:0]  alu_fn,
  output logic        cb_mode,
  output logic        illegal,
  output logic [15:0] pc,
  output logic [7:0]  ir
);

  localparam logic       ADDR_PC      = 1'b1;
  localparam logic [1:0] CTL_NOP      = 2'd0;
  localparam logic [1:0] CTL_LD_R8_D8 = 2'd1;
  localparam logic [1:0] CTL_ALU_R8   = 2'd2;
  localparam logic [1:0] CTL_HALT     = 2'd3;

  logic [15:0] pc_q;
  logic [7:0]  ir_q;
  logic        cb_q;
  logic        illegal_q;
  logic        fetch_en;
  logic        ir_load;
  logic        opcode_illegal;

  always_comb begin
    fetch_en = (addr_sel == ADDR_PC) && !halt;
    ir_load  = mem_to_ir && fetch_en;
    mem_rd   = fetch_en;
    mem_addr = fetch_en ? pc_q : 16'h0000;
  end

  // Classified on the incoming byte so the flag rises together with the IR load.
  always_comb begin
    opcode_illegal = 1'b0;
    case (mem_rdata)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: opcode_illegal = 1'b1;
      default: opcode_illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      cb_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (!halt) begin
        if (pc_load) begin
          pc_q <= pc_load_val;
        end else if (inc_pc && (addr_sel == ADDR_PC)) begin
          pc_q <= pc_q + 16'd1;
        end
      end
      if (ir_load) begin
        ir_q <= mem_rdata;
        cb_q <= !cb_q && (ir_q == 8'hCB);
        if (!cb_q && opcode_illegal) begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  // Prefixed bytes decode as NOP until the CB table exists.
  always_comb begin
    ctl_op = CTL_NOP;
    if (!cb_q) begin
      case (ir_q)
        8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h3E: ctl_op = CTL_LD_R8_D8;
        8'h76: ctl_op = CTL_HALT;
        default: begin
          if ((ir_q[7:6] == 2'b10) && (ir_q[2:0] != 3'd6)) begin
            ctl_op = CTL_ALU_R8;
          end
        end
      endcase
    end
  end

  assign r8_dst  = ir_q[5:3];
  assign r8_src  = ir_q[2:0];
  assign alu_fn  = ir_q[5:3];
  assign cb_mode = cb_q;
  assign illegal = illegal_q;
  assign pc      = pc_q;
  assign ir      = ir_q;

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - randomized and directed bench for fetch_decode against a behavioural model
module tb_fetch_decode;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_LD   = 2'd1;
  localparam logic [1:0] OP_ALU  = 2'd2;
  localparam logic [1:0] OP_HALT = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        addr_sel = 1'b0;
  logic        inc_pc = 1'b0;
  logic        mem_to_ir = 1'b0;
  logic        halt = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [1:0]  ctl_op;
  logic [2:0]  r8_dst, r8_src, alu_fn;
  logic        cb_mode, illegal;
  logic [15:0] pc;
  logic [7:0]  ir;

  logic [7:0] mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_pc;
  logic [7:0]  m_ir;
  logic        m_cb;
  logic        m_ill;

  fetch_decode #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .addr_sel(addr_sel), .inc_pc(inc_pc),
    .mem_to_ir(mem_to_ir), .halt(halt), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .ctl_op(ctl_op), .r8_dst(r8_dst), .r8_src(r8_src),
    .alu_fn(alu_fn), .cb_mode(cb_mode), .illegal(illegal), .pc(pc), .ir(ir)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_illegal(input logic [7:0] op);
    logic [7:0] bad [11] = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                             8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};
    foreach (bad[i]) if (bad[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_op(input logic [7:0] op, input logic cb);
    int row, col;
    row = op / 8;
    col = op % 8;
    if (cb) return OP_NOP;
    if (op == 8'h76) return OP_HALT;
    if (op < 8'h40 && col == 6 && op != 8'h36) return OP_LD;
    if (op >= 8'h80 && op <= 8'hBF && col != 6) return OP_ALU;
    if (row < 0) return OP_NOP;
    return OP_NOP;
  endfunction

  // One clock: check the address mux before the edge, advance the model, check registered outputs after it.
  task automatic cycle(input logic r, input logic sel, input logic inc, input logic m2ir,
                       input logic h, input logic pl, input logic [15:0] plv);
    logic        rd;
    logic [7:0]  data;
    logic [15:0] n_pc;
    logic [7:0]  n_ir;
    logic        n_cb, n_ill;
    rst = r; addr_sel = sel; inc_pc = inc; mem_to_ir = m2ir;
    halt = h; pc_load = pl; pc_load_val = plv;
    #1;
    rd = sel && !h;
    chk("mem_rd", {31'd0, mem_rd}, {31'd0, rd});
    chk("mem_addr", {16'd0, mem_addr}, {16'd0, (rd ? m_pc : 16'h0000)});
    data = mem[m_pc];
    n_pc = m_pc; n_ir = m_ir; n_cb = m_cb; n_ill = m_ill;
    if (r) begin
      n_pc = 16'h0000; n_ir = 8'h00; n_cb = 1'b0; n_ill = 1'b0;
    end else begin
      if (m2ir && rd) begin
        n_ir = data;
        n_cb = (m_cb == 1'b0) && (m_ir == 8'hCB);
        if (!m_cb && is_illegal(data)) n_ill = 1'b1;
      end
      if (!h) begin
        if (pl) n_pc = plv;
        else if (inc && sel) n_pc = 16'((32'(m_pc) + 1) % 65536);
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ir = n_ir; m_cb = n_cb; m_ill = n_ill;
    chk("pc", {16'd0, pc}, {16'd0, m_pc});
    chk("ir", {24'd0, ir}, {24'd0, m_ir});
    chk("cb_mode", {31'd0, cb_mode}, {31'd0, m_cb});
    chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
    chk("ctl_op", {30'd0, ctl_op}, {30'd0, model_op(m_ir, m_cb)});
    chk("r8_dst", {29'd0, r8_dst}, {29'd0, 3'((m_ir / 8) % 8)});
    chk("r8_src", {29'd0, r8_src}, {29'd0, 3'(m_ir % 8)});
    chk("alu_fn", {29'd0, alu_fn}, {29'd0, 3'((m_ir / 8) % 8)});
  endtask

  task automatic fetch();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h0000] = 8'h3E; mem[16'h0001] = 8'h5A;
    mem[16'h0002] = 8'h91; mem[16'h0003] = 8'h96;
    mem[16'h1234] = 8'hCB; mem[16'h1235] = 8'h37; mem[16'h1236] = 8'h80;
    mem[16'h1237] = 8'h76; mem[16'h1238] = 8'hD3;
    mem[16'h1239] = 8'h00; mem[16'h123A] = 8'h06;
    m_pc = 16'h0000; m_ir = 8'h00; m_cb = 1'b0; m_ill = 1'b0;

    // Reset fetch
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("reset_pc", {16'd0, pc}, 32'h0000);
    chk("reset_ir", {24'd0, ir}, 32'h00);
    chk("reset_op", {30'd0, ctl_op}, {30'd0, OP_NOP});
    chk("reset_dst", {29'd0, r8_dst}, 32'd0);
    fetch();
    chk("ld_ir", {24'd0, ir}, 32'h3E);
    chk("ld_op", {30'd0, ctl_op}, {30'd0, OP_LD});
    chk("ld_dst", {29'd0, r8_dst}, 32'd7);
    chk("ld_pc", {16'd0, pc}, 32'h0001);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("imm_pc", {16'd0, pc}, 32'h0002);
    chk("imm_ir_hold", {24'd0, ir}, 32'h3E);

    // ALU decode
    fetch();
    chk("alu_op", {30'd0, ctl_op}, {30'd0, OP_ALU});
    chk("alu_fn", {29'd0, alu_fn}, 32'd2);
    chk("alu_src", {29'd0, r8_src}, 32'd1);
    fetch();
    chk("alu_hl_op", {30'd0, ctl_op}, {30'd0, OP_NOP});

    // Wrap and load priority
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("wrap_pc", {16'd0, pc}, 32'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    chk("load_over_inc", {16'd0, pc}, 32'h1234);

    // CB prefix
    fetch();
    chk("cb0_mode", {31'd0, cb_mode}, 32'd0);
    chk("cb0_op", {30'd0, ctl_op}, {30'd0, OP_NOP});
    fetch();
    chk("cb1_mode", {31'd0, cb_mode}, 32'd1);
    chk("cb1_op", {30'd0, ctl_op}, {30'd0, OP_NOP});
    fetch();
    chk("cb2_mode", {31'd0, cb_mode}, 32'd0);
    chk("cb2_op", {30'd0, ctl_op}, {30'd0, OP_ALU});

    // Halt freeze
    fetch();
    chk("halt_op", {30'd0, ctl_op}, {30'd0, OP_HALT});
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      chk("halt_pc", {16'd0, pc}, 32'h1238);
      chk("halt_ir", {24'd0, ir}, 32'h76);
      chk("halt_rd", {31'd0, mem_rd}, 32'd0);
    end

    // Illegal flag, then reset under halt
    fetch();
    chk("ill_set", {31'd0, illegal}, 32'd1);
    chk("ill_op", {30'd0, ctl_op}, {30'd0, OP_NOP});
    fetch();
    fetch();
    chk("ill_sticky", {31'd0, illegal}, 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("rst_ill", {31'd0, illegal}, 32'd0);
    chk("rst_pc", {16'd0, pc}, 32'h0000);
    chk("rst_ir", {24'd0, ir}, 32'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
